mem_bus_if: RTL

- Downstream stage of the unaligned-access splitter.
- Consumes aligned word read/write requests, with a byte-enable mask, and runs them as single transactions on the external synchronous memory bus.
- Returns one-cycle acks and registered read data to the splitter.
- Sits between the splitter and the memory/IO fabric; owns bus timing, wait states and read/write arbitration.

---
 rtl/mem_bus_if_if.sv | 57 +++++
 rtl/mem_bus_if.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if_if.sv
// -----------------------------------------------------------------------------
// mem_bus_if_if.sv
// Interfaces used by mem_bus_if.
//
//   mem_req_if : word request channel from the unaligned-access splitter.
//     master modport = splitter (drives requests, receives acks/read data)
//     slave  modport = mem_bus_if
//     Signals: read_req, write_req, addr[31:0], write_data[31:0],
//              write_msk[3:0], read_ack, write_ack, read_data[31:0]
//
//   mem_ext_if : external synchronous memory bus.
//     master modport = mem_bus_if (drives the bus cycle)
//     slave  modport = memory / IO fabric
//     Signals: bus_cs, bus_we, bus_addr[31:0], bus_be[3:0], bus_wdata[31:0],
//              bus_rdata[31:0], bus_ready, bus_err
// -----------------------------------------------------------------------------
interface mem_req_if;
  logic        read_req;
  logic        write_req;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  write_msk;
  logic        read_ack;
  logic        write_ack;
  logic [31:0] read_data;

  modport master (
    output read_req, write_req, addr, write_data, write_msk,
    input  read_ack, write_ack, read_data
  );

  modport slave (
    input  read_req, write_req, addr, write_data, write_msk,
    output read_ack, write_ack, read_data
  );
endinterface

interface mem_ext_if;
  logic        bus_cs;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;

  modport master (
    output bus_cs, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_cs, bus_we, bus_addr, bus_be, bus_wdata, bus_err,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/mem_bus_if.sv
// -----------------------------------------------------------------------------
// mem_bus_if.sv
// Bus stage behind the unaligned-access splitter. Takes aligned word read and
// write requests (with byte-enable mask) and runs each as a single transaction
// on the external synchronous memory bus, returning a one-cycle ack and
// registered read data.
//
// Ports:
//   clk   : clock
//   rstn  : asynchronous active-low reset
//   req   : mem_req_if.slave  - request channel from the splitter
//   bus   : mem_ext_if.master - external memory bus
//
// Parameters:
//   TIMEOUT_CYCLES : wait-state limit (1..255); only used when the bus
//                    timeout is enabled.
//
// Build option:
//   MEM_BUS_IF_TIMEOUT_EN : when defined, an 8-bit wait counter aborts a bus
//   cycle after TIMEOUT_CYCLES cycles without bus_ready; the ack is then
//   accompanied by a one-cycle bus_err pulse (reads return 32'hFFFF_FFFF).
//   When undefined, bus cycles wait indefinitely and bus_err is tied 0.
//
// Sequencing: IDLE -> RD/WR -> ACK -> GAP -> IDLE. GAP is a dead cycle so a
// request level still held across the ack edge is never issued twice.
// -----------------------------------------------------------------------------
module mem_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rstn,
  mem_req_if.slave   req,
  mem_ext_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    ACK,
    GAP
  } state_t;

  state_t state;

  // Elaboration-time guard on the counter range.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bus_if: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef MEM_BUS_IF_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;
`endif

  // NOTE: every state and output register, including read_data, sits in the
  // async reset so an access aborted by rstn leaves nothing half-driven.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      req.read_ack  <= 1'b0;
      req.write_ack <= 1'b0;
      req.read_data <= 32'h0;
      bus.bus_cs    <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'h0;
`ifdef MEM_BUS_IF_TIMEOUT_EN
      bus.bus_err   <= 1'b0;
      wait_cnt      <= 8'd0;
`endif
    end else begin
      // NOTE: non-blocking defaults followed by later assignments in the same
      // block: the last one wins, which turns the acks into single-cycle
      // pulses without a separate clear path.
      req.read_ack  <= 1'b0;
      req.write_ack <= 1'b0;
`ifdef MEM_BUS_IF_TIMEOUT_EN
      bus.bus_err   <= 1'b0;
`endif

      case (state)
        IDLE: begin
          // Read has priority; a concurrent write stays pending and is picked
          // up on the next visit to IDLE.
          if (req.read_req) begin
            state         <= RD;
            bus.bus_cs    <= 1'b1;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= {req.addr[31:2], 2'b00};
            bus.bus_be    <= 4'b1111;
`ifdef MEM_BUS_IF_TIMEOUT_EN
            wait_cnt      <= 8'd0;
`endif
          end else if (req.write_req) begin
            if (req.write_msk != 4'b0000) begin
              state         <= WR;
              bus.bus_cs    <= 1'b1;
              bus.bus_we    <= 1'b1;
              bus.bus_addr  <= {req.addr[31:2], 2'b00};
              bus.bus_be    <= req.write_msk;
              bus.bus_wdata <= req.write_data;
`ifdef MEM_BUS_IF_TIMEOUT_EN
              wait_cnt      <= 8'd0;
`endif
            end else begin
              // Null write: nothing to put on the bus, acknowledge directly.
              state         <= ACK;
              req.write_ack <= 1'b1;
            end
          end
        end

        RD: begin
          if (bus.bus_ready) begin
            state         <= ACK;
            bus.bus_cs    <= 1'b0;
            req.read_ack  <= 1'b1;
            req.read_data <= bus.bus_rdata;
          end
`ifdef MEM_BUS_IF_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LIMIT) begin
            state         <= ACK;
            bus.bus_cs    <= 1'b0;
            req.read_ack  <= 1'b1;
            req.read_data <= 32'hFFFF_FFFF;
            bus.bus_err   <= 1'b1;
          end else begin
            wait_cnt      <= wait_cnt + 8'd1;
          end
`endif
        end

        WR: begin
          if (bus.bus_ready) begin
            state         <= ACK;
            bus.bus_cs    <= 1'b0;
            req.write_ack <= 1'b1;
          end
`ifdef MEM_BUS_IF_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LIMIT) begin
            state         <= ACK;
            bus.bus_cs    <= 1'b0;
            req.write_ack <= 1'b1;
            bus.bus_err   <= 1'b1;
          end else begin
            wait_cnt      <= wait_cnt + 8'd1;
          end
`endif
        end

        // Ack pulse is on the outputs during this state; it is cleared by
        // the defaults above.
        ACK: state <= GAP;

        // Dead cycle: requester has updated or dropped its request by now.
        GAP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_BUS_IF_TIMEOUT_EN
  assign bus.bus_err = 1'b0;
`endif

endmodule
